// File: rtl/shift_tx_pkg.sv
// -----------------------------------------------------------------------------
// shift_tx_pkg
// Shared definitions for the shift-register transmit sequencer.
//   state_e      : 3-bit FSM encoding (ST_IDLE .. ST_GAP)
//   DATA_W_DEF   : default word width (matches the 8-bit shift register)
//   cnt_width()  : width needed to hold a counter value of n-1 (minimum 1)
// -----------------------------------------------------------------------------
package shift_tx_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  // Bits needed to count down from n-1 to 0; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_tx_ctrl_if
// Word-source handshake into the transmit sequencer.
//   tx_valid : source holds a word
//   tx_data  : word, sampled only when the handshake completes
//   tx_ready : sequencer can accept
// Handshake: a word transfers on a rising clk edge where tx_valid and tx_ready
// are both high. The source keeps tx_valid/tx_data stable until that edge;
// tx_ready never depends on tx_valid.
// Modports: master = word source, slave = sequencer.
// -----------------------------------------------------------------------------
interface shift_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/shift_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_bit_counter
// Loadable down-counter with terminal-count flag. Load has priority over
// decrement; the count holds at zero instead of wrapping.
// Ports:
//   clk, nReset : clock, synchronous active-low reset (count <= RST_VAL)
//   load_i      : load load_val_i this edge
//   load_val_i  : value to load
//   en_i        : decrement this edge (when not loading and non-zero)
//   count_o     : current count
//   tc_o        : count is zero
// -----------------------------------------------------------------------------
module shift_bit_counter #(
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == '0);

endmodule

// File: rtl/shift_register_8bit.sv
// -----------------------------------------------------------------------------
// shift_register_8bit
// 8-bit parallel-load, left-shifting register. data_out is the MSB, so a
// sequence of ShiftR cycles presents the word MSB first; data_in fills the LSB.
// Ports:
//   clk, nReset  : clock, synchronous active-low reset (register cleared)
//   Load         : capture parallel_in (has priority over ShiftR)
//   ShiftR       : shift one place towards the MSB
//   parallel_in  : word to load
//   data_in      : bit shifted into the LSB
//   data_out     : current MSB
// -----------------------------------------------------------------------------
module shift_register_8bit (
  input  logic       clk,
  input  logic       nReset,
  input  logic       Load,
  input  logic       ShiftR,
  input  logic [7:0] parallel_in,
  input  logic       data_in,
  output logic       data_out
);

  logic [7:0] reg_q;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      reg_q <= '0;
    end else if (Load) begin
      reg_q <= parallel_in;
    end else if (ShiftR) begin
      reg_q <= {reg_q[6:0], data_in};
    end
  end

  assign data_out = reg_q[7];

endmodule

// File: rtl/shift_tx_ctrl.sv
// -----------------------------------------------------------------------------
// shift_tx_ctrl
// Sequencer for an external parallel-load shift register. Accepts a word on
// the tx handshake, loads the register, shifts it out MSB first one bit per
// clk, frames the stream with ser_valid / frame_start / frame_done and then
// idles GAP_CYCLES cycles before accepting the next word.
// FSM: IDLE -> LOAD -> SHIFT -> [PARITY] -> GAP -> IDLE; all outputs decode
// from the registered state.
// Optional feature: define SHIFT_TX_PARITY_EN to append one even-parity bit
// after the data bits (frame_done then moves to the parity cycle).
// Ports:
//   clk, nReset  : clock, synchronous active-low reset
//   tx           : word handshake (slave side)
//   sr_load      : shift register Load
//   sr_shift     : shift register ShiftR
//   sr_parallel  : shift register parallel_in (captured word)
//   sr_data_in   : shift register data_in (zero fill)
//   sr_serial    : shift register data_out (MSB)
//   ser_out      : framed serial bit (0 when ser_valid is low)
//   ser_valid    : ser_out is meaningful
//   bit_idx      : index of the data bit on ser_out
//   frame_start  : 1-cycle pulse in LOAD
//   frame_done   : 1-cycle pulse in the last serial cycle of a frame
//   state_o      : current FSM state (debug)
// -----------------------------------------------------------------------------
module shift_tx_ctrl
  import shift_tx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              nReset,
  shift_tx_ctrl_if.slave    tx,
  output logic              sr_load,
  output logic              sr_shift,
  output logic [DATA_W-1:0] sr_parallel,
  output logic              sr_data_in,
  input  logic              sr_serial,
  output logic              ser_out,
  output logic              ser_valid,
  output logic [CNT_W-1:0]  bit_idx,
  output logic              frame_start,
  output logic              frame_done,
  output logic [2:0]        state_o
);

  localparam int               GAP_W    = cnt_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] BIT_TOP  = CNT_W'(DATA_W - 1);
  // Where a finished frame goes once its last serial cycle is over.
  localparam state_e           ST_AFTER = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q;
  logic              hold_en;

  logic              bit_load, bit_en, bit_tc;
  logic [CNT_W-1:0]  bit_cnt;
  logic              gap_load, gap_en, gap_tc;
  logic              ser_bit;

  // Bit index: reloaded to DATA_W-1 in LOAD and again on the last data bit,
  // so it rests at the top value outside SHIFT.
  shift_bit_counter #(
    .W       (CNT_W),
    .RST_VAL (BIT_TOP)
  ) u_bit_cnt (
    .clk        (clk),
    .nReset     (nReset),
    .load_i     (bit_load),
    .load_val_i (BIT_TOP),
    .en_i       (bit_en),
    .count_o    (bit_cnt),
    .tc_o       (bit_tc)
  );

  // Gap length: loaded with GAP_CYCLES-1 on the way into GAP; GAP exits on tc.
  shift_bit_counter #(
    .W       (GAP_W),
    .RST_VAL ('0)
  ) u_gap_cnt (
    .clk        (clk),
    .nReset     (nReset),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .en_i       (gap_en),
    .count_o    (),
    .tc_o       (gap_tc)
  );

  always_comb begin
    state_d     = state_q;
    tx.tx_ready = 1'b0;
    hold_en     = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    ser_valid   = 1'b0;
    ser_bit     = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    bit_load    = 1'b0;
    bit_en      = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx.tx_ready = 1'b1;
        if (tx.tx_valid) begin
          hold_en = 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        sr_load     = 1'b1;
        frame_start = 1'b1;
        bit_load    = 1'b1;
        state_d     = ST_SHIFT;
      end

      ST_SHIFT: begin
        sr_shift  = 1'b1;
        ser_valid = 1'b1;
        ser_bit   = sr_serial;
        bit_en    = 1'b1;
        if (bit_tc) begin
          bit_load = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
          state_d  = ST_PARITY;
`else
          frame_done = 1'b1;
          gap_load   = 1'b1;
          state_d    = ST_AFTER;
`endif
        end
      end

`ifdef SHIFT_TX_PARITY_EN
      ST_PARITY: begin
        ser_valid  = 1'b1;
        ser_bit    = ^hold_q;
        frame_done = 1'b1;
        gap_load   = 1'b1;
        state_d    = ST_AFTER;
      end
`endif

      ST_GAP: begin
        gap_en = 1'b1;
        if (gap_tc) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hold_en) begin
        hold_q <= tx.tx_data;
      end
    end
  end

  assign sr_parallel = hold_q;
  assign sr_data_in  = 1'b0;
  assign ser_out     = ser_bit;
  assign bit_idx     = (state_q == ST_PARITY) ? '0 : bit_cnt;
  assign state_o     = state_q;

endmodule
